// File: rtl/conv_encoder_tx.sv
// Rate-1/2 convolutional encoder and serializer.
// One info bit in, two coded bits out, K-1 tail bits.
module conv_encoder_tx #(
  parameter int unsigned FRAME_LEN = 14,
  parameter int unsigned K         = 3,
  parameter logic [K-1:0] G0       = 3'b111,
  parameter logic [K-1:0] G1       = 3'b101
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  output logic out_first,
  output logic frame_done,
  output logic busy
);

  localparam int IW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(K);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    EMIT0,
    EMIT1,
    DONE
  } state_t;

  state_t         state;
  logic [K-2:0]   sr;
  logic           c0_q;
  logic           c1_q;
  logic           first_q;
  logic [IW-1:0]  info_cnt;
  logic [TW-1:0]  tail_cnt;

  // Trellis input vectors: MSB is the current bit
  logic [K-1:0] v_in;
  logic [K-1:0] v_tail;

  assign v_in   = {in_bit, sr};
  assign v_tail = {1'b0, sr};

  // Frame sequencing, encoding and shift register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      c0_q     <= 1'b0;
      c1_q     <= 1'b0;
      first_q  <= 1'b0;
      info_cnt <= '0;
      tail_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sr       <= '0;
            info_cnt <= '0;
            tail_cnt <= '0;
            first_q  <= 1'b0;
            state    <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            c0_q     <= ^(v_in & G0);
            c1_q     <= ^(v_in & G1);
            sr       <= v_in[K-1:1];
            first_q  <= (info_cnt == '0);
            info_cnt <= info_cnt + 1'b1;
            state    <= EMIT0;
          end
        end
        EMIT0: state <= EMIT1;
        EMIT1: begin
          if (info_cnt < IW'(FRAME_LEN)) begin
            state <= ACCEPT;
          end else if (tail_cnt < TW'(K - 1)) begin
            c0_q     <= ^(v_tail & G0);
            c1_q     <= ^(v_tail & G1);
            sr       <= v_tail[K-1:1];
            first_q  <= 1'b0;
            tail_cnt <= tail_cnt + 1'b1;
            state    <= EMIT0;
          end else begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state
  assign in_ready   = (state == ACCEPT);
  assign out_valid  = (state == EMIT0) || (state == EMIT1);
  assign out_bit    = ((state == EMIT0) && c0_q) ||
                      ((state == EMIT1) && c1_q);
  assign out_first  = (state == EMIT0) && first_q;
  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Bench for conv_encoder_tx: convolution model,
// per-cycle output compare, directed frames.
module tb_conv_encoder_tx;

  localparam int N = 14;
  localparam int K = 3;
  localparam int L = 2 * (N + K - 1);
  localparam bit [2:0] G0 = 3'b111;
  localparam bit [2:0] G1 = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready, out_bit, out_valid;
  logic out_first, frame_done, busy;

  conv_encoder_tx dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_bit(in_bit),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_bit(out_bit),
    .out_valid(out_valid),
    .out_first(out_first),
    .frame_done(frame_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit exp_all[$];
  bit exp_q[$];
  bit expf_q[$];
  int vcyc[$];
  int vcount = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Coded stream = info bits plus K-1 zeros convolved with G0/G1
  task automatic build(input bit b[$]);
    int idx;
    bit u, c0, c1;
    exp_all.delete();
    for (int n = 0; n < b.size() + K - 1; n++) begin
      c0 = 1'b0;
      c1 = 1'b0;
      for (int j = 0; j < K; j++) begin
        idx = n - j;
        u = (idx >= 0 && idx < b.size()) ? b[idx] : 1'b0;
        c0 ^= G0[K-1-j] & u;
        c1 ^= G1[K-1-j] & u;
      end
      exp_all.push_back(c0);
      exp_all.push_back(c1);
    end
  endtask

  task automatic mk(input logic [N-1:0] v, output bit q[$]);
    q.delete();
    for (int i = N - 1; i >= 0; i--) q.push_back(v[i]);
  endtask

  // Output checker against the expected stream
  always @(negedge clk) begin
    bit e, ef;
    cyc++;
    if (rst_n && chk_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          ef = expf_q.pop_front();
          chk("out_bit", out_bit, e);
          chk("out_first", out_first, ef);
          vcount++;
          vcyc.push_back(cyc);
        end
      end else begin
        chk("idle_out", {out_bit, out_first}, 0);
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    if (!ok) chk("ready_timeout", in_ready, 1);
  endtask

  task automatic run_frame(input bit b[$],
                           input int stall_at,
                           input bit tailchk);
    bit ok;
    int t;
    build(b);
    exp_q = exp_all;
    expf_q.delete();
    for (int i = 0; i < L; i++) expf_q.push_back(i == 0);
    vcyc.delete();
    vcount = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0;
        wait_ready(ok);
        if (!ok) return;
        for (int s = 0; s < 5; s++) begin
          chk("stall_ready", in_ready, 1);
          chk("stall_out", out_valid, 0);
          start = 1'b1;
          @(negedge clk);
        end
        start = 1'b0;
      end
      in_bit = b[i];
      in_valid = 1'b1;
      wait_ready(ok);
      if (!ok) return;
      @(posedge clk);
      @(negedge clk);
      chk("lat_valid", out_valid, 1);
      chk("lat_c0", out_bit, exp_all[2*i]);
    end
    in_valid = 1'b0;
    t = 0;
    while (!frame_done && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", frame_done, 1);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    #1;
    chk("busy_fall", busy, 0);
    chk("done_pulse", frame_done, 0);
    chk("nbits", vcount, L);
    chk("q_empty", exp_q.size(), 0);
    chk("done_cnt", done_cnt, 1);
    if (tailchk && vcyc.size() >= 6) begin
      chk("tail_b2b",
          vcyc[vcyc.size()-1] - vcyc[vcyc.size()-6], 5);
      chk("done_gap",
          done_cyc - vcyc[vcyc.size()-1], 1);
    end
  endtask

  function automatic int head(input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v = (v << 1) | int'(exp_all[i]);
    return v;
  endfunction

  function automatic int tail6();
    int v = 0;
    for (int i = L - 6; i < L; i++) v = (v << 1) | int'(exp_all[i]);
    return v;
  endfunction

  initial begin
    bit fb[$];
    logic [N-1:0] v;

    #12;
    chk("reset_outs",
        {busy, in_ready, out_valid,
         out_bit, out_first, frame_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of EMIT1
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_bit = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_emit1",
        {out_valid, out_bit, out_first}, 3'b110);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_rst",
        {busy, in_ready, out_valid,
         out_bit, out_first, frame_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    v = 14'b01101001110100;
    mk(v, fb);
    run_frame(fb, -1, 1'b0);

    v = '0;
    mk(v, fb);
    run_frame(fb, -1, 1'b0);

    v = 14'b10000000000000;
    mk(v, fb);
    build(fb);
    chk("model_imp", head(6), 6'b111011);
    run_frame(fb, -1, 1'b0);

    v = 14'b11010011101001;
    mk(v, fb);
    build(fb);
    chk("model_1101", head(8), 8'b11010100);
    run_frame(fb, -1, 1'b0);

    v = 14'b00000000000001;
    mk(v, fb);
    build(fb);
    chk("model_last1", tail6(), 6'b111011);
    run_frame(fb, -1, 1'b1);

    v = 14'b01101011000101;
    mk(v, fb);
    run_frame(fb, 4, 1'b1);

    repeat (3) @(negedge clk);
    chk("final_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
